// File: rtl/level_pkg.sv
// Shared types and defaults for the level write sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package level_pkg;

  localparam int DEFAULT_ADDR_W   = 6;
  localparam int DEFAULT_DIV_LOG2 = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/clk_en_div.sv
// Free-running power-of-two divider producing an enable strobe and a square wave.
// Latency: clk_en high on the cycle the counter is all-ones; clkdiv is the counter MSB.
// Backpressure: none; runs every cycle out of reset.
module clk_en_div #(
  parameter int DIV_LOG2 = 1
) (
  input  logic Clk,
  input  logic Reset_n,
  output logic clk_en,
  output logic clkdiv
);

  logic [DIV_LOG2-1:0] cnt;

  // Divider counter, wraps naturally at 2^DIV_LOG2.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_LOG2'(1);
    end
  end

  assign clk_en = &cnt;
  assign clkdiv = cnt[DIV_LOG2-1];

endmodule

// File: rtl/level_write_sequencer.sv
// Walks addr 0..2^ADDR_W-1 with write_en on a start request, then pulses done for one cycle.
// Latency: addr 0 / write_en one cycle after a start condition; done one cycle after the last accepted word.
// Backpressure: wr_ready=0 holds addr and write_en; requests while busy are held (depth 1) or dropped by QUEUE_REQ.
module level_write_sequencer
  import level_pkg::*;
#(
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int DIV_LOG2  = DEFAULT_DIV_LOG2,
  parameter int QUEUE_REQ = 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              vs,
  input  logic              initialize_level,
  input  logic              new_level,
  input  logic              no_update,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic              write_en,
  output logic              busy,
  output logic              done,
  output logic              level_pending,
  output logic              update_change,
  output logic              clk_en,
  output logic              clkdiv
);

  localparam logic QUEUE_EN = (QUEUE_REQ != 0);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic              new_level_q;
  logic              vs_q;
  logic              req_flag;
  logic              pending_q;
  logic              no_update_q;
  logic              upd_armed;
  logic              update_change_q;

  logic nl_rise;
  logic vs_rise;
  logic req_live;
  logic start_cond;
  logic last_word;

  assign nl_rise    = new_level & ~new_level_q;
  assign vs_rise    = vs & ~vs_q;
  // A vs rise in the same cycle the request is looked at cancels it.
  assign req_live   = req_flag & ~vs_rise;
  assign start_cond = initialize_level | req_live | pending_q;
  assign last_word  = (addr_q == {ADDR_W{1'b1}});

  // Next-state selection for the IDLE -> WRITE -> DONE walk.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_cond) state_nxt = WRITE;
      WRITE:   if (wr_ready && last_word) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, address, request/pending flags and input edge detectors.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state           <= IDLE;
      addr_q          <= '0;
      new_level_q     <= 1'b0;
      vs_q            <= 1'b0;
      req_flag        <= 1'b0;
      pending_q       <= 1'b0;
      no_update_q     <= 1'b0;
      upd_armed       <= 1'b0;
      update_change_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      new_level_q <= new_level;
      vs_q        <= vs;
      // A request is looked at exactly once on the following cycle: it
      // starts a sequence, moves into pending, is dropped, or is cancelled
      // by vs. So the flag only needs to hold the latest rise.
      req_flag    <= nl_rise;

      // Address restarts on entry to WRITE and never steps past the last word.
      if (state == IDLE) begin
        if (start_cond) addr_q <= '0;
      end else if (state == WRITE && wr_ready && !last_word) begin
        addr_q <= addr_q + ADDR_W'(1);
      end

      // Pending is consumed when IDLE starts; while busy it collects requests.
      if (state == IDLE) begin
        pending_q <= 1'b0;
      end else if (start_cond && QUEUE_EN) begin
        pending_q <= 1'b1;
      end

      // First edge after reset only captures no_update, so the first
      // comparison is against the value present at reset release.
      no_update_q <= no_update;
      if (!upd_armed) begin
        upd_armed       <= 1'b1;
        update_change_q <= 1'b0;
      end else begin
        update_change_q <= no_update ^ no_update_q;
      end
    end
  end

  assign addr          = addr_q;
  assign write_en      = (state == WRITE);
  assign done          = (state == DONE);
  assign busy          = (state != IDLE);
  assign level_pending = pending_q;
  assign update_change = update_change_q;

  clk_en_div #(
    .DIV_LOG2(DIV_LOG2)
  ) u_div (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .clk_en  (clk_en),
    .clkdiv  (clkdiv)
  );

endmodule

// File: tb/tb_level_write_sequencer.sv
// Bench for level_write_sequencer: one queuing instance (DIV_LOG2=2) and one dropping instance (DIV_LOG2=1).
// Latency: outputs sampled 1 time unit after each rising edge; inputs driven at the same point.
// Backpressure: wr_ready driven directly (held low, high or random).
module tb_level_write_sequencer;

  localparam int WORDS = 64;

  logic Clk;
  logic Reset_n;
  logic vs;
  logic initialize_level;
  logic new_level;
  logic no_update;
  logic wr_ready;

  logic [5:0] addr0, addr1;
  logic we0, busy0, done0, pend0, uc0, ce0, cd0;
  logic we1, busy1, done1, pend1, uc1, ce1, cd1;

  logic [12:0] obs0, obs1;
  assign obs0 = {addr0, we0, busy0, done0, pend0, uc0, ce0, cd0};
  assign obs1 = {addr1, we1, busy1, done1, pend1, uc1, ce1, cd1};

  int total = 0;
  int bad   = 0;

  level_write_sequencer #(.ADDR_W(6), .DIV_LOG2(2), .QUEUE_REQ(1)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .vs(vs), .initialize_level(initialize_level),
    .new_level(new_level), .no_update(no_update), .wr_ready(wr_ready),
    .addr(addr0), .write_en(we0), .busy(busy0), .done(done0),
    .level_pending(pend0), .update_change(uc0), .clk_en(ce0), .clkdiv(cd0)
  );

  level_write_sequencer #(.ADDR_W(6), .DIV_LOG2(1), .QUEUE_REQ(0)) dut_nq (
    .Clk(Clk), .Reset_n(Reset_n), .vs(vs), .initialize_level(initialize_level),
    .new_level(new_level), .no_update(no_update), .wr_ready(wr_ready),
    .addr(addr1), .write_en(we1), .busy(busy1), .done(done1),
    .level_pending(pend1), .update_change(uc1), .clk_en(ce1), .clkdiv(cd1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: a sequence is "on" while fewer than WORDS words have
  // been accepted, plus one closing cycle once all WORDS are in.
  bit m_on[2]      = '{1'b0, 1'b0};
  int m_written[2] = '{0, 0};
  bit m_pend[2]    = '{1'b0, 1'b0};
  bit m_req = 1'b0, m_nl = 1'b0, m_vs = 1'b0, m_uc = 1'b0, m_prev_upd = 1'b0;
  int m_k = 0;

  task automatic model_step();
    bit rise, vsr, start;
    if (!Reset_n) begin
      for (int i = 0; i < 2; i++) begin
        m_on[i] = 1'b0; m_written[i] = 0; m_pend[i] = 1'b0;
      end
      m_req = 1'b0; m_nl = 1'b0; m_vs = 1'b0; m_uc = 1'b0; m_prev_upd = 1'b0; m_k = 0;
    end else begin
      rise = new_level && !m_nl;
      vsr  = vs && !m_vs;
      for (int i = 0; i < 2; i++) begin
        start = initialize_level || (m_req && !vsr) || m_pend[i];
        if (!m_on[i]) begin
          if (start) begin m_on[i] = 1'b1; m_written[i] = 0; m_pend[i] = 1'b0; end
        end else begin
          if (start && i == 0) m_pend[i] = 1'b1;
          if (m_written[i] == WORDS) m_on[i] = 1'b0;
          else if (wr_ready) m_written[i] = m_written[i] + 1;
        end
      end
      m_req = rise; m_nl = new_level; m_vs = vs;
      m_uc = (m_k >= 1) && (no_update != m_prev_upd);
      m_prev_upd = no_update;
      m_k = m_k + 1;
    end
  endtask

  function automatic logic [12:0] model_exp(int i);
    logic [5:0] a;
    int ph;
    a  = (m_written[i] >= WORDS) ? 6'd63 : 6'(m_written[i]);
    ph = (i == 0) ? (m_k % 4) : (m_k % 2);
    return {a, m_on[i] && (m_written[i] < WORDS), m_on[i], m_on[i] && (m_written[i] == WORDS),
            m_pend[i], m_uc, (ph == ((i == 0) ? 3 : 1)), ((i == 0) ? (ph >= 2) : (ph == 1))};
  endfunction

  task automatic cyc();
    @(posedge Clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    repeat (2) cyc();
    total++; if (obs0 !== 13'd0) begin bad++; $display("FAIL reset_q got=%h exp=%h", obs0, 13'd0); end
    total++; if (obs1 !== 13'd0) begin bad++; $display("FAIL reset_nq got=%h exp=%h", obs1, 13'd0); end
    Reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_single();
    wr_ready = 1'b1; initialize_level = 1'b1; cyc(); initialize_level = 1'b0;
    for (int i = 0; i < WORDS; i++) begin
      total++;
      if ({we0, addr0} !== {1'b1, 6'(i)}) begin
        bad++; $display("FAIL single_addr i=%0d got=%h exp=%h", i, {we0, addr0}, {1'b1, 6'(i)});
      end
      cyc();
    end
    total++; if ({done0, busy0, we0} !== 3'b110) begin bad++; $display("FAIL single_done got=%b exp=110", {done0, busy0, we0}); end
    cyc();
    total++; if ({done0, busy0} !== 2'b00) begin bad++; $display("FAIL single_idle got=%b exp=00", {done0, busy0}); end
  endtask

  task automatic test_stall();
    int stall, n_we, n10;
    bit seen;
    stall = 5; n_we = 0; n10 = 0; seen = 1'b0;
    wr_ready = 1'b1; initialize_level = 1'b1; cyc(); initialize_level = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      if (done0) seen = 1'b1;
      else begin
        if (we0) n_we++;
        if (we0 && addr0 == 6'd10) n10++;
        if (we0 && addr0 == 6'd10 && stall > 0) begin wr_ready = 1'b0; stall--; end
        else wr_ready = 1'b1;
        cyc();
      end
    end
    wr_ready = 1'b1;
    total++; if (!seen) begin bad++; $display("FAIL stall_timeout got=0 exp=1"); end
    total++; if (n_we != 69) begin bad++; $display("FAIL stall_length got=%0d exp=69", n_we); end
    total++; if (n10 != 6) begin bad++; $display("FAIL stall_hold got=%0d exp=6", n10); end
    cyc();
  endtask

  task automatic test_queue();
    bit hit;
    int nq_busy;
    wr_ready = 1'b1; initialize_level = 1'b1; cyc(); initialize_level = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin if (we0 && addr0 == 6'd20) hit = 1'b1; else cyc(); end
    total++; if (!hit) begin bad++; $display("FAIL queue_reach20 got=%0d exp=20", addr0); end
    new_level = 1'b1; cyc(); new_level = 1'b0; cyc();
    total++; if ({pend0, pend1} !== 2'b10) begin bad++; $display("FAIL queue_pending got=%b exp=10", {pend0, pend1}); end
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin if (done0) hit = 1'b1; else cyc(); end
    total++; if (!hit) begin bad++; $display("FAIL queue_done_timeout got=0 exp=1"); end
    cyc();
    total++; if ({busy0, pend0, busy1} !== 3'b010) begin bad++; $display("FAIL queue_gap got=%b exp=010", {busy0, pend0, busy1}); end
    cyc();
    total++;
    if ({we0, addr0, pend0, busy1} !== {1'b1, 6'd0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL queue_restart got=%h exp=%h", {we0, addr0, pend0, busy1}, {1'b1, 6'd0, 1'b0, 1'b0});
    end
    nq_busy = 0; hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      if (done0) hit = 1'b1;
      else begin if (busy1) nq_busy++; cyc(); end
    end
    total++; if (!hit || nq_busy != 0) begin bad++; $display("FAIL queue_drop got_nq_busy=%0d exp=0 done_seen=%0d", nq_busy, hit); end
    cyc();
  endtask

  task automatic test_vs();
    bit hit;
    int nb;
    new_level = 1'b0; vs = 1'b0; wr_ready = 1'b1; cyc(); cyc();
    new_level = 1'b1; vs = 1'b1; cyc();
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL vs_same_wait got=%b exp=0", busy0); end
    cyc();
    total++; if ({we0, addr0, we1} !== {1'b1, 6'd0, 1'b1}) begin bad++; $display("FAIL vs_same_start got=%h exp=%h", {we0, addr0, we1}, {1'b1, 6'd0, 1'b1}); end
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin if (done0) hit = 1'b1; else cyc(); end
    total++; if (!hit) begin bad++; $display("FAIL vs_done_timeout got=0 exp=1"); end
    new_level = 1'b0; vs = 1'b0; cyc(); cyc();
    new_level = 1'b1; cyc();
    vs = 1'b1; cyc();
    nb = 0;
    for (int c = 0; c < 4; c++) begin if (busy0 || busy1) nb++; cyc(); end
    total++; if (nb != 0) begin bad++; $display("FAIL vs_cancel got_busy_cycles=%0d exp=0", nb); end
    new_level = 1'b0; vs = 1'b0; cyc();
  endtask

  task automatic test_update();
    logic [7:0] p0, p1;
    p0 = '0; p1 = '0;
    no_update = ~no_update;
    for (int j = 1; j <= 8; j++) begin
      cyc();
      p0[j-1] = uc0; p1[j-1] = uc1;
      if (j == 3) no_update = ~no_update;
    end
    total++; if (p0 !== 8'b0000_1001) begin bad++; $display("FAIL update_q got=%b exp=00001001", p0); end
    total++; if (p1 !== 8'b0000_1001) begin bad++; $display("FAIL update_nq got=%b exp=00001001", p1); end
  endtask

  task automatic test_back_to_back();
    bit seen;
    int gap, n_gaps, gaps_bad;
    logic [12:0] e0, e1;
    seen = 1'b0; gap = 0; n_gaps = 0; gaps_bad = 0;
    initialize_level = 1'b1;
    for (int c = 0; c < 400; c++) begin
      wr_ready = ($urandom_range(0, 3) != 0);
      cyc();
      e0 = model_exp(0); e1 = model_exp(1);
      total++; if (obs0 !== e0) begin bad++; $display("FAIL b2b_q c=%0d got=%h exp=%h", c, obs0, e0); end
      total++; if (obs1 !== e1) begin bad++; $display("FAIL b2b_nq c=%0d got=%h exp=%h", c, obs1, e1); end
      if (busy0) begin
        if (gap > 0) begin n_gaps++; if (gap != 1) gaps_bad++; end
        gap = 0; seen = 1'b1;
      end else if (seen) gap++;
    end
    total++; if (n_gaps < 2 || gaps_bad != 0) begin bad++; $display("FAIL b2b_gaps got_gaps=%0d got_bad=%0d exp_bad=0", n_gaps, gaps_bad); end
    initialize_level = 1'b0; wr_ready = 1'b1;
    for (int c = 0; c < 200 && (busy0 || busy1); c++) cyc();
    total++; if ({busy0, busy1} !== 2'b00) begin bad++; $display("FAIL b2b_drain got=%b exp=00", {busy0, busy1}); end
  endtask

  task automatic test_random();
    logic [12:0] e0, e1;
    for (int c = 0; c < 1500; c++) begin
      initialize_level = ($urandom_range(0, 99) < 1);
      if ($urandom_range(0, 99) < 3) new_level = ~new_level;
      if ($urandom_range(0, 99) < 4) vs = ~vs;
      if ($urandom_range(0, 99) < 5) no_update = ~no_update;
      wr_ready = ($urandom_range(0, 4) != 0);
      cyc();
      e0 = model_exp(0); e1 = model_exp(1);
      total++; if (obs0 !== e0) begin bad++; $display("FAIL rand_q c=%0d got=%h exp=%h", c, obs0, e0); end
      total++; if (obs1 !== e1) begin bad++; $display("FAIL rand_nq c=%0d got=%h exp=%h", c, obs1, e1); end
    end
    initialize_level = 1'b0; new_level = 1'b0; vs = 1'b0; wr_ready = 1'b1;
    for (int c = 0; c < 300 && (busy0 || busy1); c++) cyc();
    cyc();
  endtask

  task automatic test_reset_mid();
    bit hit;
    int nd;
    logic [7:0] pce0, pcd0, pce1, pcd1, pmisc;
    wr_ready = 1'b1; initialize_level = 1'b1; cyc(); initialize_level = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin if (we0 && addr0 == 6'd30) hit = 1'b1; else cyc(); end
    total++; if (!hit) begin bad++; $display("FAIL rmid_reach30 got=%0d exp=30", addr0); end
    #2 Reset_n = 1'b0;
    #1;
    total++; if (obs0 !== 13'd0) begin bad++; $display("FAIL rmid_async_q got=%h exp=%h", obs0, 13'd0); end
    total++; if (obs1 !== 13'd0) begin bad++; $display("FAIL rmid_async_nq got=%h exp=%h", obs1, 13'd0); end
    no_update = ~no_update;
    nd = 0;
    for (int c = 0; c < 3; c++) begin cyc(); if (done0 || done1 || busy0 || busy1) nd++; end
    total++; if (nd != 0) begin bad++; $display("FAIL rmid_hold got=%0d exp=0", nd); end
    Reset_n = 1'b1;
    pce0 = '0; pcd0 = '0; pce1 = '0; pcd1 = '0; pmisc = '0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      pce0[k-1] = ce0; pcd0[k-1] = cd0; pce1[k-1] = ce1; pcd1[k-1] = cd1;
      pmisc[k-1] = uc0 | uc1 | busy0 | done0;
    end
    total++; if (pce0 !== 8'b0100_0100) begin bad++; $display("FAIL div4_clk_en got=%b exp=01000100", pce0); end
    total++; if (pcd0 !== 8'b0110_0110) begin bad++; $display("FAIL div4_clkdiv got=%b exp=01100110", pcd0); end
    total++; if (pce1 !== 8'b0101_0101) begin bad++; $display("FAIL div2_clk_en got=%b exp=01010101", pce1); end
    total++; if (pcd1 !== 8'b0101_0101) begin bad++; $display("FAIL div2_clkdiv got=%b exp=01010101", pcd1); end
    total++; if (pmisc !== 8'b0) begin bad++; $display("FAIL rmid_quiet got=%b exp=00000000", pmisc); end
  endtask

  initial begin
    Reset_n = 1'b0; vs = 1'b0; initialize_level = 1'b0; new_level = 1'b0;
    no_update = 1'b0; wr_ready = 1'b0;
    test_reset();
    test_single();
    test_stall();
    test_queue();
    test_vs();
    test_update();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/level_write_sequencer.md
LEVEL_WRITE_SEQUENCER -- requirements
Module: level_write_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, giving the write address width; the sequence length is 2^ADDR_W words.
REQ-002 SHALL have parameter DIV_LOG2, default 1, giving the divider ratio as 2^DIV_LOG2; the legal range is 1..8.
REQ-003 SHALL have parameter QUEUE_REQ, default 1; when 1, a request that arrives while busy is held pending; when 0, it is dropped.
REQ-004 SHALL have the following ports, clock and reset first:
- Clk  in  1  sole clock; all logic is on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- vs  in  1  vertical sync, level input synchronous to Clk.
- initialize_level  in  1  level request to start a write sequence.
- new_level  in  1  pulse or level request to start a write sequence.
- no_update  in  1  status level; any change on it is flagged.
- wr_ready  in  1  downstream accepts the current word this cycle.
- addr  out  ADDR_W  current write address.
- write_en  out  1  addr is valid; a word is written when write_en && wr_ready.
- busy  out  1  a sequence is in progress.
- done  out  1  one-cycle pulse after the last word is accepted.
- level_pending  out  1  a request is held, waiting for the next start.
- update_change  out  1  one-cycle pulse when no_update differs from its value on the previous cycle.
- clk_en  out  1  one-cycle strobe every 2^DIV_LOG2 cycles.
- clkdiv  out  1  square wave at Clk/2^DIV_LOG2.

Function
REQ-005 SHALL use a state machine with states IDLE, WRITE and DONE.
REQ-006 IDLE SHALL go to WRITE on the cycle after a start condition: initialize_level=1, or new_level has risen, or level_pending=1.
REQ-007 new_level SHALL be rising-edge detected against its registered previous value; a rise SHALL set an internal request flag.
REQ-008 The request flag SHALL be cleared by a rising edge of vs, unless a new_level rise occurs on the same cycle, in which case the flag is set.
REQ-009 On entry to WRITE, addr SHALL be 0 and write_en SHALL be 1.
REQ-010 In WRITE, addr SHALL increment by 1 only on cycles where wr_ready=1; when wr_ready=0, addr and write_en SHALL hold.
REQ-011 When wr_ready=1 and addr=2^ADDR_W-1, the state SHALL go to DONE and write_en SHALL fall on the next cycle; addr SHALL NOT wrap to 0 while write_en=1.
REQ-012 DONE SHALL last exactly one cycle, with done=1, and SHALL then go to IDLE.
REQ-013 busy SHALL be 1 in WRITE and in DONE.
REQ-014 A start condition while busy SHALL set level_pending when QUEUE_REQ=1 (depth 1; further requests merge) and SHALL be ignored when QUEUE_REQ=0.
REQ-015 level_pending SHALL clear on the cycle IDLE goes to WRITE.
REQ-016 initialize_level held high SHALL cause back-to-back sequences with exactly one IDLE cycle between them.
REQ-017 update_change SHALL be 1 on the cycle after no_update differs from its previous registered value; the first comparison after reset SHALL be against the value sampled at reset release.
REQ-018 A DIV_LOG2-bit free-running counter SHALL drive both dividers: clk_en=1 when the counter is all-ones; clkdiv is the counter MSB.
REQ-019 addr SHALL use ADDR_W-bit unsigned arithmetic; the end-of-sequence compare SHALL be against the all-ones value of that width.

Reset
REQ-020 While Reset_n=0, outputs SHALL be: state IDLE, addr=0, write_en=0, busy=0, done=0, level_pending=0, update_change=0, clk_en=0, clkdiv=0, and the divider counter 0.
REQ-021 Reset asserted mid-sequence SHALL abort it immediately with no done pulse; pending and request flags SHALL be lost.
REQ-022 Reset SHALL be released synchronously to Clk by the top-level synchroniser; this block assumes a clean deassertion.

Structure
REQ-023 The state enum (IDLE, WRITE, DONE) SHALL live in shared package level_pkg, with DEFAULT_ADDR_W=6.
REQ-024 The divider SHALL be a separate sub-module clk_en_div (parameter DIV_LOG2; outputs clk_en and clkdiv).
REQ-025 All sequencing and edge detection SHALL be in one always_ff block plus one always_comb next-state block; no derived clocks.

Verification
REQ-026 Pulse initialize_level for 1 cycle with wr_ready=1 and ADDR_W=6 -> addr 0..63 on 64 consecutive cycles, then done=1 for 1 cycle, then busy=0.
REQ-027 Start a sequence, then hold wr_ready=0 for 5 cycles at addr=10 -> addr stays 10 and write_en stays 1 for those 5 cycles; total length is 69 cycles.
REQ-028 With QUEUE_REQ=1, a new_level rise at addr=20 -> level_pending=1, and a second sequence starts 1 cycle after done; with QUEUE_REQ=0, no second sequence.
REQ-029 Raise new_level and vs on the same cycle -> request taken and a sequence starts; a vs rise alone after a request -> request cleared.
REQ-030 Toggle no_update twice, 3 cycles apart -> exactly two update_change pulses, each 1 cycle long.
REQ-031 Assert Reset_n=0 at addr=30 -> all outputs at reset values, no done pulse; with DIV_LOG2=2, clk_en every 4th cycle and clkdiv period 4 after release.
